fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage RV32I pipeline: PC register, next-PC selection, and the IF/ID pipeline register.
- Its InstrD output feeds the decode stage. Bits [31:7] go to the immediate extender; the other fields go to the control and register-file decode.
- It accepts branch/jump redirects from execute and stall/flush controls from the hazard unit.
- It keeps a free-running count of instructions accepted into decode.

---
 rtl/fetch_stage.sv | 64 ++++++
 tb/tb_fetch_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID
// pipeline register, plus a count of instructions accepted into decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] PCF,
  input  logic [31:0] InstrF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [31:0] FetchCount
);

  logic [31:0] pc_plus4_f;
  logic [31:0] pc_next;
  logic        load_d;
  logic        unused_target_low;

  assign pc_plus4_f = PCF + 32'd4;
  // Low target bits are forced to zero, so they never reach the PC.
  assign unused_target_low = ^PCTargetE[1:0];
  assign load_d = !FlushD && !StallD;

  always_comb begin
    pc_next = pc_plus4_f;
    if (PCSrcE)      pc_next = {PCTargetE[31:2], 2'b00};
    else if (StallF) pc_next = PCF;
  end

  always_ff @(posedge clk) begin
    if (rst) PCF <= RESET_PC;
    else     PCF <= pc_next;
  end

  // Flush outranks stall: a squashed slot must never be held in decode.
  always_ff @(posedge clk) begin
    if (rst || FlushD) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      InstrD   <= InstrF;
      PCD      <= PCF;
      PCPlus4D <= pc_plus4_f;
      ValidD   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         FetchCount <= 32'd0;
    else if (load_d) FetchCount <= FetchCount + 32'd1;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized hazard traffic,
// checked against a cycle-level model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance, RESET_PC = 0
  logic        rst = 1'b1;
  logic [31:0] pcf, instr_f, pc_target_e;
  logic        pc_src_e = 1'b0, stall_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0;
  logic [31:0] instr_d, pcd, pc_plus4_d, fetch_count;
  logic        valid_d;

  // wrap instance, RESET_PC near the top of the address space
  logic        rst_w = 1'b1;
  logic [31:0] pcf_w, instr_f_w;
  logic [31:0] instr_d_w, pcd_w, pc_plus4_d_w, fetch_count_w;
  logic        valid_d_w;

  function automatic logic [31:0] imem(input logic [31:0] addr);
    return 32'h0010_0093 + (addr >> 2);
  endfunction

  assign instr_f   = imem(pcf);
  assign instr_f_w = imem(pcf_w);

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .PCF(pcf), .InstrF(instr_f),
    .PCSrcE(pc_src_e), .PCTargetE(pc_target_e),
    .StallF(stall_f), .StallD(stall_d), .FlushD(flush_d),
    .InstrD(instr_d), .PCD(pcd), .PCPlus4D(pc_plus4_d),
    .ValidD(valid_d), .FetchCount(fetch_count)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(NOP)) dut_w (
    .clk(clk), .rst(rst_w), .PCF(pcf_w), .InstrF(instr_f_w),
    .PCSrcE(1'b0), .PCTargetE(32'd0),
    .StallF(1'b0), .StallD(1'b0), .FlushD(1'b0),
    .InstrD(instr_d_w), .PCD(pcd_w), .PCPlus4D(pc_plus4_d_w),
    .ValidD(valid_d_w), .FetchCount(fetch_count_w)
  );

  // StallD without StallF is an illegal hazard-unit combination.
  always @(posedge clk) begin
    if (!rst) assert (!(stall_d && !stall_f)) else $error("illegal StallD without StallF");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state: what the decode stage should hold after each edge.
  logic [31:0] m_pc, m_instr, m_pcd, m_p4, m_cnt;
  logic        m_valid;

  // Apply one cycle of inputs, advance the model by the fetch rules, compare.
  task automatic cycle(input logic r, input logic src, input logic [31:0] tgt,
                       input logic sf, input logic sd, input logic fl);
    logic [31:0] n_pc, n_instr, n_pcd, n_p4, n_cnt;
    logic        n_valid;
    rst = r; pc_src_e = src; pc_target_e = tgt;
    stall_f = sf; stall_d = sd; flush_d = fl;
    n_pc = m_pc; n_instr = m_instr; n_pcd = m_pcd; n_p4 = m_p4;
    n_valid = m_valid; n_cnt = m_cnt;
    if (r) begin
      n_pc = 32'd0; n_instr = NOP; n_pcd = 0; n_p4 = 0; n_valid = 0; n_cnt = 0;
    end else begin
      if (src)      n_pc = tgt & 32'hFFFF_FFFC;
      else if (!sf) n_pc = m_pc + 32'd4;
      if (fl) begin
        n_instr = NOP; n_pcd = 0; n_p4 = 0; n_valid = 0;
      end else if (!sd) begin
        n_instr = imem(m_pc); n_pcd = m_pc; n_p4 = m_pc + 32'd4; n_valid = 1;
        n_cnt = m_cnt + 32'd1;
      end
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_pcd = n_pcd; m_p4 = n_p4;
    m_valid = n_valid; m_cnt = n_cnt;
    check("pcf", pcf, m_pc);
    check("instr_d", instr_d, m_instr);
    check("pcd", pcd, m_pcd);
    check("pc_plus4_d", pc_plus4_d, m_p4);
    check("valid_d", {31'd0, valid_d}, {31'd0, m_valid});
    check("fetch_count", fetch_count, m_cnt);
  endtask

  initial begin
    logic [31:0] cnt_hold;
    m_pc = 0; m_instr = NOP; m_pcd = 0; m_p4 = 0; m_valid = 0; m_cnt = 0;
    pc_target_e = 32'd0;

    // reset
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    check("rst_pcf", pcf, 32'h0);
    check("rst_instr_d", instr_d, NOP);
    check("rst_valid", {31'd0, valid_d}, 32'd0);
    check("rst_count", fetch_count, 32'd0);

    // free run
    cycle(0, 0, 0, 0, 0, 0);
    check("run_pcf1", pcf, 32'h4);
    check("run_pcd1", pcd, 32'h0);
    check("run_instr1", instr_d, 32'h0010_0093);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    check("run_pcf3", pcf, 32'hC);
    check("run_count3", fetch_count, 32'd3);
    cycle(0, 0, 0, 0, 0, 0);
    check("run_pcf4", pcf, 32'h10);

    // redirect with flush at PCF = 0x10
    cnt_hold = fetch_count;
    cycle(0, 1, 32'h103, 0, 0, 1);
    check("redir_pcf", pcf, 32'h100);
    check("redir_instr", instr_d, NOP);
    check("redir_valid", {31'd0, valid_d}, 32'd0);
    check("redir_count", fetch_count, cnt_hold);
    cycle(0, 0, 0, 0, 0, 0);
    check("redir_pcd", pcd, 32'h100);
    check("redir_instr_t", instr_d, imem(32'h100));

    // load-use stall with PCF = 0x20, PCD = 0x1C
    cycle(0, 1, 32'h1C, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0);
    check("pre_stall_pcf", pcf, 32'h20);
    check("pre_stall_pcd", pcd, 32'h1C);
    cnt_hold = fetch_count;
    for (int i = 0; i < 2; i++) begin
      cycle(0, 0, 0, 1, 1, 0);
      check("stall_pcf", pcf, 32'h20);
      check("stall_pcd", pcd, 32'h1C);
      check("stall_count", fetch_count, cnt_hold);
    end
    cycle(0, 0, 0, 0, 0, 0);
    check("post_stall_pcf", pcf, 32'h24);
    check("post_stall_pcd", pcd, 32'h20);

    // redirect beats StallF; flush beats StallD
    cycle(0, 1, 32'h40, 1, 0, 0);
    check("redir_over_stall", pcf, 32'h40);
    cycle(0, 0, 0, 1, 1, 1);
    check("flush_over_stall_i", instr_d, NOP);
    check("flush_over_stall_v", {31'd0, valid_d}, 32'd0);

    // reset during stall and redirect
    cycle(1, 1, 32'h80, 1, 1, 0);
    check("mid_rst_pcf", pcf, 32'h0);
    check("mid_rst_valid", {31'd0, valid_d}, 32'd0);
    check("mid_rst_count", fetch_count, 32'd0);

    // randomized hazard traffic (never StallD without StallF)
    for (int i = 0; i < 400; i++) begin
      logic r, src, sf, sd, fl;
      logic [31:0] tgt;
      r   = ($urandom_range(0, 63) == 0);
      src = ($urandom_range(0, 7) == 0);
      tgt = $urandom;
      sd  = ($urandom_range(0, 5) == 0);
      sf  = sd || ($urandom_range(0, 9) == 0);
      fl  = src || ($urandom_range(0, 15) == 0);
      cycle(r, src, tgt, sf, sd, fl);
    end
    cycle(0, 0, 0, 0, 0, 0);

    // PC wrap on the second instance
    @(negedge clk); rst_w = 1'b1;
    @(posedge clk); #1;
    check("wrap_pcf0", pcf_w, 32'hFFFF_FFF8);
    rst_w = 1'b0;
    @(posedge clk); #1;
    check("wrap_pcf1", pcf_w, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    check("wrap_pcf2", pcf_w, 32'h0000_0000);
    check("wrap_pcd", pcd_w, 32'hFFFF_FFFC);
    check("wrap_p4d", pc_plus4_d_w, 32'h0000_0000);
    check("wrap_count", fetch_count_w, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
